fixed_mul_acc: RTL and testbench
================================

# fixed_mul_acc

Parametrised, pipelined signed fixed-point multiply / multiply-accumulate unit with configurable fractional bits, rounding and saturation, under valid/ready flow control. It is the streaming successor to the package-level Q10 multiply helper. It provides the arithmetic core for the FM demodulator's FIR, IIR and de-emphasis stages. It runs in either per-sample multiply mode or in multi-term accumulate mode framed by first/last markers.

## Interface
- WIDTH, 32, operand and result width (signed two's complement)
- FRAC, 10, fractional bits of operands and result (Q(WIDTH-FRAC).FRAC); 1 <= FRAC < WIDTH
- GUARD, 8, extra accumulator headroom bits
- ROUND, 1, 1 = round half up before the shift; 0 = truncate (arithmetic shift, toward -inf)
- SAT, 1, 1 = clamp to the signed WIDTH range; 0 = wrap (keep the low WIDTH bits)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_first  in  1  MAC mode: beat starts a new sum
- in_last  in  1  MAC mode: beat ends the sum
- mode  in  1  0 = multiply, 1 = MAC; sampled per beat and carried down the pipe
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  WIDTH  result
- out_ovf  out  1  result exceeded the WIDTH range (clamped if SAT=1, wrapped if SAT=0)

## Operation
- A beat transfers when in_valid && in_ready; a result transfers when out_valid && out_ready.
- Global enable: en = !out_valid || out_ready. in_ready = en. All pipeline registers advance only when en=1.
- S1: register in_a, in_b, first, last, mode and valid.
- S2: signed 2·WIDTH-bit product.
- S3 accumulator, ACC = 2·WIDTH+GUARD bits, sign-extended:
  - On a valid S2 beat with mode=0, or with mode=1 and first=1: acc = product.
  - Otherwise (mode=1, first=0): acc = acc + product.
  - The accumulator holds its value on bubbles.
- Result candidate r = (src + (ROUND ? 2^(FRAC-1) : 0)) >>> FRAC, where src is the new acc value. Shift is arithmetic.
- Overflow: ovf = (r > 2^(WIDTH-1)-1) || (r < -2^(WIDTH-1)).
  - SAT=1: out_data is clamped to 0x7FF..F or 0x800..0.
  - SAT=0: out_data = r[WIDTH-1:0].
  - out_ovf = ovf in both cases.
- Output register loads and out_valid=1:
  - mode=0: on every valid beat.
  - mode=1: only on a beat with last=1. Intermediate MAC beats produce no output.
- first=1 together with last=1 gives a single-term sum: result = rounded product.
- last without a prior first continues the existing acc. Undefined framing is not flagged.
- Mixing mode mid-sum: a mode=0 beat overwrites acc. Any following MAC beats without first add to that product.

## Timing
- Reset values: out_valid=0, out_data=0, out_ovf=0, all stage valids=0, acc=0. in_ready=1 in the cycle after reset deasserts.
- Reset mid-operation discards all in-flight beats and any partial sum. No output is produced for them.
- Latency: a beat accepted at edge k produces out_valid high after edge k+3, provided no stall occurs.
- Throughput: 1 beat/cycle when out_ready=1.
- Stall: while out_valid && !out_ready:
  - out_data and out_ovf stay stable.
  - in_ready=0 and no stage advances.
- Up to 3 beats are held in flight during a stall. They are released in order, with no loss or duplication.
- Result accepted with a simultaneous new load: when out_ready=1 and S3 produces a result in the same cycle, out_valid stays 1 with the new data.

## Test plan
- Multiply, WIDTH=32, FRAC=10, mode=0, a=3584 (3.5), b=2048 (2.0) -> out_data=7168 (7.0), out_ovf=0, out_valid 3 cycles after acceptance.
- Rounding:
  - a=1, b=512 -> ROUND=1 gives 1; ROUND=0 gives 0.
  - a=-1, b=512 -> ROUND=1 gives 0; ROUND=0 gives -1 (0xFFFFFFFF).
- Saturation: a=b=0x7FFFFFFF:
  - SAT=1 -> out_data=0x7FFFFFFF, out_ovf=1.
  - a=0x7FFFFFFF, b=0x80000000 -> out_data=0x80000000, out_ovf=1.
  - SAT=0 -> low 32 bits of r, out_ovf=1.
- MAC, mode=1: four beats a=b=1024, first on beat 0, last on beat 3 -> exactly one output 4096. Then a single beat with first=last=1, a=b=2048 -> 4096.
- Backpressure: stream 10 multiply beats with out_ready low for 5 cycles mid-stream:
  - in_ready=0 while stalled.
  - out_data is held stable.
  - All 10 results arrive in order with none lost.
- Reset mid-sum: assert reset after 2 of 4 MAC beats, then send a fresh sum with first -> only the fresh sum is output, and out_valid=0 immediately after reset.

Source files
------------

// File: rtl/fixed_mul_acc.sv
// Pipelined signed fixed-point multiply / multiply-accumulate with rounding and saturation.
// Four register stages (operands, product, accumulator, output) advance together under one enable.
module fixed_mul_acc #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 10,
  parameter int GUARD = 8,
  parameter int ROUND = 1,
  parameter int SAT   = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int AW = PW + GUARD;
  localparam logic signed [AW:0] RND_C =
    (ROUND != 0) ? ((AW+1)'(1) <<< (FRAC - 1)) : '0;

  logic en;

  logic                    s1_valid, s1_first, s1_last, s1_mode;
  logic signed [WIDTH-1:0] s1_a, s1_b;

  logic                    s2_valid, s2_first, s2_last, s2_mode;
  logic signed [PW-1:0]    s2_prod;
  logic signed [PW-1:0]    mult;

  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    prod_ext;
  logic                    s3_emit;

  logic signed [AW:0]      rnd;
  logic signed [AW:0]      r;
  logic [AW:WIDTH-1]       hi;
  logic                    ovf;
  logic [WIDTH-1:0]        sat_data;
  logic [WIDTH-1:0]        res;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign mult     = PW'(s1_a) * PW'(s1_b);
  assign prod_ext = AW'(s2_prod);

  // Rounding/shift/clamp read the accumulator as committed by the emitting beat.
  assign rnd      = (AW+1)'(acc) + RND_C;
  assign r        = rnd >>> FRAC;
  assign hi       = r[AW:WIDTH-1];
  assign ovf      = !((&hi) || !(|hi));
  assign sat_data = r[AW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign res      = ((SAT != 0) && ovf) ? sat_data : r[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_mode  <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_first <= in_first;
      s1_last  <= in_last;
      s1_mode  <= mode;
      s1_a     <= in_a;
      s1_b     <= in_b;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_mode  <= 1'b0;
      s2_prod  <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_mode  <= s1_mode;
      s2_prod  <= mult;
    end
  end

  // Multiply beats and MAC first beats restart the sum; other MAC beats add.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc     <= '0;
      s3_emit <= 1'b0;
    end else if (en) begin
      s3_emit <= s2_valid && (!s2_mode || s2_last);
      if (s2_valid) begin
        if (!s2_mode || s2_first) acc <= prod_ext;
        else                      acc <= acc + prod_ext;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      out_valid <= s3_emit;
      if (s3_emit) begin
        out_data <= res;
        out_ovf  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_fixed_mul_acc.sv
// Scoreboard bench: two instances (round+saturate, truncate+wrap) share one stimulus stream.
module tb_fixed_mul_acc;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_first, in_last, mode, out_ready;
  logic [31:0] in_a, in_b;
  logic        in_ready1, out_valid1, out_ovf1;
  logic [31:0] out_data1;
  logic        in_ready0, out_valid0, out_ovf0;
  logic [31:0] out_data0;

  always #5 clock = ~clock;

  fixed_mul_acc #(.WIDTH(32), .FRAC(10), .GUARD(8), .ROUND(1), .SAT(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last), .mode(mode),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ovf(out_ovf1)
  );

  fixed_mul_acc #(.WIDTH(32), .FRAC(10), .GUARD(8), .ROUND(0), .SAT(0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last), .mode(mode),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ovf(out_ovf0)
  );

  typedef struct {
    logic [31:0] d;
    logic        o;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   vecs = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares on every output transfer, checks stall behaviour.
  logic        stalled_prev = 1'b0;
  logic [31:0] held;
  exp_t        e;
  always @(negedge clock) begin
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) check("stall_hold", out_data1, held);
      if (out_valid1 && !out_ready) check("stall_in_ready", {31'b0, in_ready1}, 32'd0);
      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) begin
          vecs++; fails++;
          $display("FAIL unexpected_out_r1: got 0x%08h expected no output", out_data1);
        end else begin
          e = q1.pop_front();
          check("data_r1", out_data1, e.d);
          check("ovf_r1", {31'b0, out_ovf1}, {31'b0, e.o});
        end
      end
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) begin
          vecs++; fails++;
          $display("FAIL unexpected_out_r0: got 0x%08h expected no output", out_data0);
        end else begin
          e = q0.pop_front();
          check("data_r0", out_data0, e.d);
          check("ovf_r0", {31'b0, out_ovf0}, {31'b0, e.o});
        end
      end
      stalled_prev = out_valid1 && !out_ready;
      held = out_data1;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic f, input logic l,
                      input logic m, input bit emit, input logic [31:0] e1, input logic o1,
                      input logic [31:0] e0, input logic o0);
    int   n = 0;
    exp_t x;
    in_a = a; in_b = b; in_first = f; in_last = l; mode = m; in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready1) begin
      vecs++; fails++;
      $display("FAIL send_timeout: in_ready 0 expected 1");
    end
    if (emit) begin
      x.d = e1; x.o = o1; q1.push_back(x);
      x.d = e0; x.o = o0; q0.push_back(x);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("drain_q_empty", 32'(q1.size() + q0.size()), 32'd0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; mode = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_out_valid", {31'b0, out_valid1}, 32'd0);
    check("rst_out_data", out_data1, 32'd0);
    check("rst_out_ovf", {31'b0, out_ovf1}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("rst_in_ready", {31'b0, in_ready1}, 32'd1);

    // 3.5 * 2.0 = 7.0 with latency check
    send(32'd3584, 32'd2048, 0, 0, 0, 1, 32'd7168, 0, 32'd7168, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("latency_k2_idle", {31'b0, out_valid1}, 32'd0);
    @(posedge clock); #1;
    check("latency_k3_valid", {31'b0, out_valid1}, 32'd1);

    // rounding, saturation and wrap
    send(32'd1, 32'd512, 0, 0, 0, 1, 32'd1, 0, 32'd0, 0);
    send(32'hFFFFFFFF, 32'd512, 0, 0, 0, 1, 32'd0, 0, 32'hFFFFFFFF, 0);
    send(32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 0, 1, 32'h7FFFFFFF, 1, 32'hFFC00000, 1);
    send(32'h7FFFFFFF, 32'h80000000, 0, 0, 0, 1, 32'h80000000, 1, 32'h00200000, 1);

    // four-term MAC, then single-term sum
    send(32'd1024, 32'd1024, 1, 0, 1, 0, 0, 0, 0, 0);
    send(32'd1024, 32'd1024, 0, 0, 1, 0, 0, 0, 0, 0);
    send(32'd1024, 32'd1024, 0, 0, 1, 0, 0, 0, 0, 0);
    send(32'd1024, 32'd1024, 0, 1, 1, 1, 32'd4096, 0, 32'd4096, 0);
    send(32'd2048, 32'd2048, 1, 1, 1, 1, 32'd4096, 0, 32'd4096, 0);

    // multiply beat seeds acc, then a MAC beat without first adds onto it
    send(32'd1024, 32'd1024, 0, 0, 0, 1, 32'd1024, 0, 32'd1024, 0);
    send(32'd1024, 32'd1024, 0, 1, 1, 1, 32'd2048, 0, 32'd2048, 0);
    drain();

    // backpressure: 10 beats with a 5-cycle stall mid-stream
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(32'((i + 1) * 1024), 32'd3072, 0, 0, 0, 1,
               32'((i + 1) * 3072), 0, 32'((i + 1) * 3072), 0);
      end
      begin
        repeat (5) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset mid-sum with a multiply beat still in flight: nothing may come out
    send(32'd1024, 32'd1024, 1, 0, 1, 0, 0, 0, 0, 0);
    send(32'd1024, 32'd1024, 0, 0, 1, 0, 0, 0, 0, 0);
    send(32'd5120, 32'd1024, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("mid_rst_out_valid", {31'b0, out_valid1}, 32'd0);
    send(32'd2048, 32'd1024, 1, 0, 1, 0, 0, 0, 0, 0);
    send(32'd1024, 32'd1024, 0, 1, 1, 1, 32'd3072, 0, 32'd3072, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
